// File: rtl/fft_mag_streamer.sv
// fft_mag_streamer: reads one frame of complex FFT bins from the result RAM
// and streams squared magnitudes (re^2 + im^2) >> 1, one bin per clock, with
// a start pulse on bin 0 and an index companion for the serial peak finder.
module fft_mag_streamer #(
    parameter int N_BINS = 256,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    output logic [8:0]               rd_addr,
    input  logic signed [DATA_W-1:0] rd_re,
    input  logic signed [DATA_W-1:0] rd_im,
    output logic                     start_out,
    output logic                     mag_valid,
    output logic [31:0]              mag_out,
    output logic [8:0]               idx_out
);

    localparam int         P_W       = 2 * DATA_W;
    localparam logic [8:0] LAST_ADDR = 9'(N_BINS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t      state_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [8:0]  addr_reg;

    // Address-side tags that travel alongside the RAM read latency.
    logic              issue;
    logic              issue_first;
    logic              issue_last;
    logic [RD_LAT-1:0] vld_sr_reg;
    logic [RD_LAT-1:0] first_sr_reg;
    logic [RD_LAT-1:0] last_sr_reg;

    // Square stage.
    logic                  m_vld_reg;
    logic                  m_first_reg;
    logic                  m_last_reg;
    logic [P_W-1:0]        re_sq_reg;
    logic [P_W-1:0]        im_sq_reg;
    logic signed [P_W-1:0] re_ext;
    logic signed [P_W-1:0] im_ext;

    // Sum/output stage.
    logic        s_vld_reg;
    logic        s_first_reg;
    logic        s_last_reg;
    logic [31:0] mag_reg;
    logic [8:0]  idx_reg;

    assign issue       = (state_reg == READ);
    assign issue_first = issue && (addr_reg == 9'd0);
    assign issue_last  = issue && (addr_reg == LAST_ADDR);

    // Sign-extend before squaring so the product carries the full width.
    assign re_ext = P_W'(rd_re);
    assign im_ext = P_W'(rd_im);

    // Frame control: accept go when idle, sweep addresses, wait for the tail.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= 9'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    addr_reg <= 9'd0;
                    if (go) begin
                        state_reg <= READ;
                        busy_reg  <= 1'b1;
                    end
                end
                READ: begin
                    if (addr_reg == LAST_ADDR) begin
                        state_reg <= DRAIN;
                        addr_reg  <= 9'd0;
                    end else begin
                        addr_reg <= addr_reg + 9'd1;
                    end
                end
                DRAIN: begin
                    // The last bin is on mag_out this cycle; done follows it.
                    if (s_vld_reg && s_last_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    addr_reg  <= 9'd0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Delay the valid/first/last tags by the RAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr_reg   <= '0;
            first_sr_reg <= '0;
            last_sr_reg  <= '0;
        end else begin
            vld_sr_reg   <= (vld_sr_reg << 1)   | RD_LAT'(issue);
            first_sr_reg <= (first_sr_reg << 1) | RD_LAT'(issue_first);
            last_sr_reg  <= (last_sr_reg << 1)  | RD_LAT'(issue_last);
        end
    end

    // Square stage: re*re and im*im are non-negative, kept as unsigned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_vld_reg   <= 1'b0;
            m_first_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            re_sq_reg   <= '0;
            im_sq_reg   <= '0;
        end else begin
            m_vld_reg   <= vld_sr_reg[RD_LAT-1];
            m_first_reg <= first_sr_reg[RD_LAT-1];
            m_last_reg  <= last_sr_reg[RD_LAT-1];
            re_sq_reg   <= re_ext * re_ext;
            im_sq_reg   <= im_ext * im_ext;
        end
    end

    // Sum stage: widen by one bit, halve, and zero the output between bins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_vld_reg   <= 1'b0;
            s_first_reg <= 1'b0;
            s_last_reg  <= 1'b0;
            mag_reg     <= 32'd0;
        end else begin
            s_vld_reg   <= m_vld_reg;
            s_first_reg <= m_vld_reg && m_first_reg;
            s_last_reg  <= m_vld_reg && m_last_reg;
            if (m_vld_reg) begin
                mag_reg <= 32'(({1'b0, re_sq_reg} + {1'b0, im_sq_reg}) >> 1);
            end else begin
                mag_reg <= 32'd0;
            end
        end
    end

    // Index companion lags the bin by one (downstream adds 1); it reads 0 on
    // bin 0 and bin 1 and settles at N_BINS-1 once the frame has passed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg <= 9'd0;
        end else if (m_vld_reg && m_first_reg) begin
            idx_reg <= 9'd0;
        end else if (s_vld_reg && !s_first_reg) begin
            idx_reg <= idx_reg + 9'd1;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign rd_addr   = addr_reg;
    assign start_out = s_first_reg;
    assign mag_valid = s_vld_reg;
    assign mag_out   = mag_reg;
    assign idx_out   = idx_reg;

endmodule

// File: tb/tb_fft_mag_streamer.sv
// tb_fft_mag_streamer: directed bench for fft_mag_streamer. Instance A uses
// the default 256-bin / RD_LAT=1 configuration, instance B 8 bins / RD_LAT=3.
module tb_fft_mag_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic go_a, go_b;

    logic               busy_a, done_a, start_a, mvalid_a;
    logic [8:0]         rd_addr_a, idx_a;
    logic signed [15:0] rd_re_a, rd_im_a;
    logic [31:0]        mag_a;

    logic               busy_b, done_b, start_b, mvalid_b;
    logic [8:0]         rd_addr_b, idx_b;
    logic signed [15:0] rd_re_b, rd_im_b;
    logic [31:0]        mag_b;

    fft_mag_streamer #(.N_BINS(256), .DATA_W(16), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .go(go_a), .busy(busy_a), .done(done_a),
        .rd_addr(rd_addr_a), .rd_re(rd_re_a), .rd_im(rd_im_a),
        .start_out(start_a), .mag_valid(mvalid_a), .mag_out(mag_a), .idx_out(idx_a)
    );

    fft_mag_streamer #(.N_BINS(8), .DATA_W(16), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .busy(busy_b), .done(done_b),
        .rd_addr(rd_addr_b), .rd_re(rd_re_b), .rd_im(rd_im_b),
        .start_out(start_b), .mag_valid(mvalid_b), .mag_out(mag_b), .idx_out(idx_b)
    );

    // RAM models: A has one cycle of read latency, B three.
    logic signed [15:0] mem_a_re [512];
    logic signed [15:0] mem_a_im [512];
    logic signed [15:0] mem_b_re [512];
    logic signed [15:0] mem_b_im [512];
    logic signed [15:0] b_re_p1, b_re_p2, b_im_p1, b_im_p2;

    always @(posedge clk) begin
        rd_re_a <= mem_a_re[rd_addr_a];
        rd_im_a <= mem_a_im[rd_addr_a];
        b_re_p1 <= mem_b_re[rd_addr_b];
        b_im_p1 <= mem_b_im[rd_addr_b];
        b_re_p2 <= b_re_p1;
        b_im_p2 <= b_im_p1;
        rd_re_b <= b_re_p2;
        rd_im_b <= b_im_p2;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor A: captures bins by position after start_out, runs a reference
    // strict-greater-than peak finder using idx_out+1.
    logic [31:0] cap_a_mag [512];
    int          cap_a_idx [512];
    int a_bin = 0, a_vcnt = 0, a_start_cyc = -1, a_last_cyc = -1, a_done_cyc = -1;
    int a_done_cnt = 0, a_tail_err = 0, a_peak_idx = -1;
    logic [31:0] a_peak = 0;

    always @(negedge clk) begin
        if (start_a === 1'b1) begin
            a_start_cyc = cyc;
            a_bin       = 0;
            a_vcnt      = 0;
            a_peak      = mag_a;
            a_peak_idx  = 0;
        end else if (mvalid_a === 1'b1 && mag_a > a_peak) begin
            a_peak     = mag_a;
            a_peak_idx = int'(idx_a) + 1;
        end
        if (mvalid_a === 1'b1) begin
            if (a_bin < 512) begin
                cap_a_mag[a_bin] = mag_a;
                cap_a_idx[a_bin] = int'(idx_a);
            end
            a_bin++;
            a_vcnt++;
            a_last_cyc = cyc;
        end else if (rst_n === 1'b1 && mag_a !== 32'd0) begin
            a_tail_err++;
        end
        if (done_a === 1'b1) begin
            a_done_cyc = cyc;
            a_done_cnt++;
        end
    end

    // Monitor B: same capture for the small instance.
    logic [31:0] cap_b_mag [16];
    int          cap_b_idx [16];
    int b_bin = 0, b_vcnt = 0, b_start_cyc = -1, b_last_cyc = -1, b_done_cyc = -1;
    int b_tail_err = 0;

    always @(negedge clk) begin
        if (start_b === 1'b1) begin
            b_start_cyc = cyc;
            b_bin       = 0;
            b_vcnt      = 0;
        end
        if (mvalid_b === 1'b1) begin
            if (b_bin < 16) begin
                cap_b_mag[b_bin] = mag_b;
                cap_b_idx[b_bin] = int'(idx_b);
            end
            b_bin++;
            b_vcnt++;
            b_last_cyc = cyc;
        end else if (rst_n === 1'b1 && mag_b !== 32'd0) begin
            b_tail_err++;
        end
        if (done_b === 1'b1) b_done_cyc = cyc;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    typedef struct {
        int          bin;
        int          re;
        int          im;
        logic [31:0] exp_mag;
        int          exp_idx;
    } vec_t;

    vec_t vt [10];

    task automatic clear_mem_a();
        for (int i = 0; i < 512; i++) begin
            mem_a_re[i] = 16'sd0;
            mem_a_im[i] = 16'sd0;
        end
    endtask

    task automatic load_table_a();
        clear_mem_a();
        for (int i = 0; i < 10; i++) begin
            mem_a_re[vt[i].bin] = 16'(vt[i].re);
            mem_a_im[vt[i].bin] = 16'(vt[i].im);
        end
    endtask

    task automatic check_table_a(input string tag);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s_mag_bin%0d", tag, vt[i].bin), 64'(cap_a_mag[vt[i].bin]), 64'(vt[i].exp_mag));
            check($sformatf("%s_idx_bin%0d", tag, vt[i].bin), 64'(cap_a_idx[vt[i].bin]), 64'(vt[i].exp_idx));
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_busy"},      64'(busy_a),    64'd0);
        check({tag, "_done"},      64'(done_a),    64'd0);
        check({tag, "_start"},     64'(start_a),   64'd0);
        check({tag, "_mag_valid"}, 64'(mvalid_a),  64'd0);
        check({tag, "_mag_out"},   64'(mag_a),     64'd0);
        check({tag, "_rd_addr"},   64'(rd_addr_a), 64'd0);
        check({tag, "_idx_out"},   64'(idx_a),     64'd0);
    endtask

    // Called on the done cycle (plus #1) of an A frame whose go was in cycle g.
    task automatic check_frame_a(input string tag, input int g);
        check({tag, "_start_cycle"}, 64'(a_start_cyc - g), 64'd4);
        check({tag, "_valid_cnt"},   64'(a_vcnt), 64'd256);
        check({tag, "_done_after"},  64'(a_done_cyc - a_last_cyc), 64'd1);
        check({tag, "_zero_tail"},   64'(a_tail_err), 64'd0);
        check({tag, "_idx_hold"},    64'(idx_a), 64'd255);
        check({tag, "_mag_after"},   64'(mag_a), 64'd0);
        check({tag, "_busy_low"},    64'(busy_a), 64'd0);
    endtask

    task automatic wait_done_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g1, g2, g3, g4, gb, dc;
        bit ok;
        logic [31:0] exp_b_mag [8];
        int          exp_b_idx [8];

        vt[0] = '{0,   1,      1,      32'd1,          0};
        vt[1] = '{1,   -1,     0,      32'd0,          0};
        vt[2] = '{2,   0,      0,      32'd0,          1};
        vt[3] = '{5,   -32768, -32768, 32'h4000_0000,  4};
        vt[4] = '{6,   3,      4,      32'd12,         5};
        vt[5] = '{37,  1000,   0,      32'd500000,     36};
        vt[6] = '{100, 0,      -300,   32'd45000,      99};
        vt[7] = '{200, 32767,  32767,  32'd1073676289, 199};
        vt[8] = '{254, -32768, 0,      32'd536870912,  253};
        vt[9] = '{255, 5,      -7,     32'd37,         254};

        exp_b_mag = '{32'd0, 32'd0, 32'd2, 32'd4, 32'd8, 32'd12, 32'd18, 32'd24};
        exp_b_idx = '{0, 0, 1, 2, 3, 4, 5, 6};

        rst_n = 1'b0;
        go_a  = 1'b0;
        go_b  = 1'b0;
        clear_mem_a();
        for (int i = 0; i < 512; i++) begin
            mem_b_re[i] = 16'sd0;
            mem_b_im[i] = 16'sd0;
        end
        for (int k = 0; k < 8; k++) mem_b_re[k] = 16'(k);

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_a("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame 1: single peak at bin 37; a stray go mid-frame must be ignored.
        mem_a_re[37] = 16'sd1000;
        @(posedge clk);
        #1 go_a = 1'b1;
        g1 = cyc;
        @(posedge clk);
        #1 go_a = 1'b0;
        check("f1_busy_after_go", 64'(busy_a), 64'd1);
        repeat (9) @(posedge clk);
        #1 go_a = 1'b1;
        @(posedge clk);
        #1 go_a = 1'b0;
        wait_done_a(ok);
        check("f1_done_seen", 64'(ok), 64'd1);
        #1;
        check_frame_a("f1", g1);
        check("f1_mag_bin37", 64'(cap_a_mag[37]), 64'd500000);
        check("f1_idx_bin37", 64'(cap_a_idx[37]), 64'd36);
        check("f1_peak_bin",  64'(a_peak_idx), 64'd37);
        check("f1_done_cnt",  64'(a_done_cnt), 64'd1);

        // Frame 2: go on the done cycle, table contents.
        load_table_a();
        go_a = 1'b1;
        g2 = cyc;
        @(posedge clk);
        #1 go_a = 1'b0;
        check("f2_busy_after_go", 64'(busy_a), 64'd1);
        wait_done_a(ok);
        check("f2_done_seen", 64'(ok), 64'd1);
        #1;
        check_frame_a("f2", g2);
        check_table_a("f2");
        check("f2_peak_bin", 64'(a_peak_idx), 64'd5);

        // Frame 3: reset asserted while bin 100 is on mag_out.
        @(posedge clk);
        #1 go_a = 1'b1;
        g3 = cyc;
        @(posedge clk);
        #1 go_a = 1'b0;
        while (cyc < g3 + 104) begin
            @(posedge clk);
            #1;
        end
        check("f3_bin100_valid", 64'(mvalid_a), 64'd1);
        check("f3_bin100_mag",   64'(mag_a),    64'd45000);
        check("f3_bin100_idx",   64'(idx_a),    64'd99);
        dc = a_done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_a("abort");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("abort_no_done", 64'(a_done_cnt - dc), 64'd0);
        check("abort_idle",    64'(busy_a), 64'd0);

        // Frame 4: full frame after the abort.
        go_a = 1'b1;
        g4 = cyc;
        @(posedge clk);
        #1 go_a = 1'b0;
        wait_done_a(ok);
        check("f4_done_seen", 64'(ok), 64'd1);
        #1;
        check_frame_a("f4", g4);
        check_table_a("f4");

        // Instance B: 8-bin ramp with RD_LAT=3.
        @(posedge clk);
        #1 go_b = 1'b1;
        gb = cyc;
        @(posedge clk);
        #1 go_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_b === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_done_seen", 64'(ok), 64'd1);
        #1;
        check("b_start_cycle", 64'(b_start_cyc - gb), 64'd6);
        check("b_valid_cnt",   64'(b_vcnt), 64'd8);
        check("b_done_after",  64'(b_done_cyc - b_last_cyc), 64'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b_mag_bin%0d", k), 64'(cap_b_mag[k]), 64'(exp_b_mag[k]));
            check($sformatf("b_idx_bin%0d", k), 64'(cap_b_idx[k]), 64'(exp_b_idx[k]));
        end
        check("b_idx_hold",  64'(idx_b), 64'd7);
        check("b_mag_after", 64'(mag_b), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("b_zero_tail", 64'(b_tail_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
